// File: rtl/scan_dump_seq.sv
// Scan dump sequencer: freezes the DUT functional clock and shifts the DUT
// scan chain out, one bit per cycle, into a SIPO buffer. Each buffer word
// is requested, filled and committed through a write-op handshake. The
// functional clock is restored when all words are committed or when a
// handshake times out.
module scan_dump_seq #(
   parameter int CHAIN_LEN = 256,
   parameter int WORD_W    = 32,
   parameter int TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       dut_clk_en,
   output logic       scan_en,
   input  logic       scan_out,
   output logic       buf_sin,
   output logic       buf_val_op,
   output logic       buf_op,
   input  logic       buf_op_ack,
   input  logic       buf_op_commit,
   input  logic       buf_scaning,
   output logic [6:0] word_cnt
);

   localparam int NWORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LASTBITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;

   localparam logic [6:0] NWORDS_V  = 7'(NWORDS);
   localparam logic [6:0] TIMEOUT_V = 7'(TIMEOUT);
   localparam logic [5:0] FULL_W    = 6'(WORD_W);
   localparam logic [5:0] LAST_W    = 6'(LASTBITS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FREEZE = 3'd1;
   localparam logic [2:0] S_REQ    = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_COMMIT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   logic [2:0] state_reg;
   logic [2:0] state_next;
   logic [5:0] bit_cnt_reg;
   logic [6:0] word_cnt_reg;
   logic [6:0] tmo_cnt_reg;
   logic       err_reg;
   logic       scaning_prev_reg;

   logic       last_word;
   logic [5:0] wbits;
   logic       scaning_fall;
   logic       tmo_hit;
   logic       word_final;

   // Bits to shift for the current word; only the last word may be short,
   // the buffer keeps shifting its full window and receives zeros as padding.
   assign last_word    = (word_cnt_reg == NWORDS_V - 7'd1);
   assign wbits        = last_word ? LAST_W : FULL_W;
   assign scan_en      = (state_reg == S_SHIFT) && buf_scaning && (bit_cnt_reg < wbits);
   assign scaning_fall = (state_reg == S_SHIFT) && scaning_prev_reg && !buf_scaning;
   assign tmo_hit      = (tmo_cnt_reg == TIMEOUT_V);
   assign word_final   = ((word_cnt_reg + 7'd1) == NWORDS_V);

   assign busy       = (state_reg != S_IDLE);
   assign done       = (state_reg == S_DONE);
   assign err        = err_reg;
   assign dut_clk_en = !((state_reg == S_FREEZE) || (state_reg == S_REQ) ||
                         (state_reg == S_SHIFT)  || (state_reg == S_COMMIT));
   assign buf_sin    = scan_en ? scan_out : 1'b0;
   assign buf_val_op = (state_reg == S_REQ);
   assign buf_op     = 1'b0;
   assign word_cnt   = word_cnt_reg;

   // Next-state selection; handshakes are sampled only in their own state.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_FREEZE;
         S_FREEZE: state_next = S_REQ;
         S_REQ: begin
            if (buf_op_ack)   state_next = S_SHIFT;
            else if (tmo_hit) state_next = S_ERR;
         end
         S_SHIFT:  if (scaning_fall) state_next = S_COMMIT;
         S_COMMIT: begin
            if (buf_op_commit) state_next = word_final ? S_DONE : S_REQ;
            else if (tmo_hit)  state_next = S_ERR;
         end
         S_DONE:   state_next = S_IDLE;
         S_ERR:    state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // State, counters and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= S_IDLE;
         bit_cnt_reg      <= 6'd0;
         word_cnt_reg     <= 7'd0;
         tmo_cnt_reg      <= 7'd0;
         err_reg          <= 1'b0;
         scaning_prev_reg <= 1'b0;
      end else begin
         state_reg <= state_next;

         // Handshake watchdog restarts on every state change.
         if (state_next != state_reg)
            tmo_cnt_reg <= 7'd0;
         else if ((state_reg == S_REQ) || (state_reg == S_COMMIT))
            tmo_cnt_reg <= tmo_cnt_reg + 7'd1;

         if ((state_reg == S_IDLE) && start)
            bit_cnt_reg <= 6'd0;
         else if ((state_reg == S_SHIFT) && (state_next != S_SHIFT))
            bit_cnt_reg <= 6'd0;
         else if (scan_en)
            bit_cnt_reg <= bit_cnt_reg + 6'd1;

         if ((state_reg == S_IDLE) && start)
            word_cnt_reg <= 7'd0;
         else if ((state_reg == S_COMMIT) && buf_op_commit)
            word_cnt_reg <= word_cnt_reg + 7'd1;

         if ((state_reg == S_IDLE) && start)
            err_reg <= 1'b0;
         else if ((state_next == S_ERR) && (state_reg != S_ERR))
            err_reg <= 1'b1;

         // Edge detector for the end of the buffer's shift window.
         scaning_prev_reg <= (state_reg == S_SHIFT) ? buf_scaning : 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_dump_seq.sv
// Directed bench for scan_dump_seq: a behavioural SIPO buffer and scan chain
// surround the sequencer; each task drives one scenario and checks inline.
module tb_scan_dump_seq;

   localparam int CHAIN_LEN = 72;
   localparam int TIMEOUT   = 8;

   localparam logic [127:0] CHAIN0 = {56'hFF_FFFF_FFFF_FFFF, 72'hA5_DEADBEEF_01234567};
   localparam logic [127:0] CHAIN1 = {56'hFF_FFFF_FFFF_FFFF, 72'h3C_CAFEF00D_89ABCDEF};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, err, dut_clk_en, scan_en, buf_sin, buf_val_op, buf_op;
   logic       scan_out = 1'b0;
   logic       buf_op_ack = 1'b0;
   logic       buf_op_commit = 1'b0;
   logic       buf_scaning = 1'b0;
   logic [6:0] word_cnt;

   int checks = 0;
   int errors = 0;

   scan_dump_seq #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
      .dut_clk_en(dut_clk_en), .scan_en(scan_en), .scan_out(scan_out), .buf_sin(buf_sin),
      .buf_val_op(buf_val_op), .buf_op(buf_op), .buf_op_ack(buf_op_ack),
      .buf_op_commit(buf_op_commit), .buf_scaning(buf_scaning), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // Buffer / chain model state
   logic [127:0] chain = '0;
   logic [31:0]  sreg = '0;
   logic [31:0]  cap [8];
   int           cap_idx = 0;
   int           m_st = 0;
   int           m_cnt = 0;
   logic         n_ack = 0, n_scan = 0, n_commit = 0, obs_se = 0;
   logic         ack_en = 1, commit_en = 1, inject = 0;
   int           se_cnt = 0, done_cnt = 0, viol = 0;

   // Observe on the falling edge, apply the buffer's response just after the rising edge.
   always begin
      @(negedge clk);
      if (scan_en) se_cnt++;
      if (done) done_cnt++;
      if (scan_en && dut_clk_en) viol++;
      if (!scan_en && buf_sin) viol++;
      obs_se = scan_en;
      if (reset) begin
         m_st = 0; n_ack = 0; n_scan = 0; n_commit = 0;
      end else begin
         case (m_st)
            0: if (buf_val_op && ack_en) begin n_ack = 1; m_st = 1; end
            1: begin n_ack = 0; n_scan = 1; m_cnt = 0; m_st = 2; end
            2: begin
               sreg = {buf_sin, sreg[31:1]};
               m_cnt++;
               if (m_cnt == 32) begin n_scan = 0; m_st = 3; end
            end
            3: begin
               if (commit_en) begin
                  n_commit = 1;
                  if (cap_idx < 8) cap[cap_idx] = sreg;
                  cap_idx++;
                  m_st = 4;
               end else m_st = 0;
            end
            default: begin n_commit = 0; m_st = 0; end
         endcase
      end
      @(posedge clk); #1;
      buf_op_ack    = n_ack;
      buf_scaning   = n_scan;
      buf_op_commit = n_commit | inject;
      inject        = 0;
      if (obs_se) chain = chain >> 1;
      scan_out = chain[0];
   end

   task automatic pulse_start;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic prep(input logic [127:0] ch);
      @(posedge clk); #1;
      chain = ch; scan_out = ch[0];
      se_cnt = 0; done_cnt = 0; cap_idx = 0; viol = 0;
   endtask

   task automatic wait_idle(output bit to);
      to = 1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy) begin to = 0; break; end
      end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (dut_clk_en !== 1'b1) begin errors++; $display("FAIL reset_clk_en got %b want 1", dut_clk_en); end
      checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en got %b want 0", scan_en); end
      checks++; if (buf_val_op !== 1'b0) begin errors++; $display("FAIL reset_val_op got %b want 0", buf_val_op); end
      checks++; if (word_cnt !== 7'd0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
      @(posedge clk); #1 reset = 0;
      $display("test_reset done");
   endtask

   task automatic test_full_dump;
      bit to;
      prep(CHAIN0);
      pulse_start;
      @(negedge clk);   // FREEZE
      checks++; if (busy !== 1'b1 || dut_clk_en !== 1'b0 || buf_val_op !== 1'b0)
         begin errors++; $display("FAIL freeze_outs got busy=%b clk_en=%b val=%b want 1,0,0", busy, dut_clk_en, buf_val_op); end
      @(negedge clk);   // REQ
      checks++; if (buf_val_op !== 1'b1 || buf_op !== 1'b0 || scan_en !== 1'b0)
         begin errors++; $display("FAIL req_outs got val=%b op=%b se=%b want 1,0,0", buf_val_op, buf_op, scan_en); end
      @(negedge clk);   // ack cycle
      @(negedge clk);   // first shift cycle
      checks++; if (scan_en !== 1'b1 || buf_val_op !== 1'b0)
         begin errors++; $display("FAIL first_shift got se=%b val=%b want 1,0", scan_en, buf_val_op); end
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL full_timeout got busy after 2000 cycles want idle"); end
      checks++; if (se_cnt != 72) begin errors++; $display("FAIL full_se_cnt got %0d want 72", se_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt got %0d want 1", done_cnt); end
      checks++; if (word_cnt !== 7'd3) begin errors++; $display("FAIL full_word_cnt got %0d want 3", word_cnt); end
      checks++; if (cap_idx != 3) begin errors++; $display("FAIL full_commits got %0d want 3", cap_idx); end
      checks++; if (cap[0] !== 32'h01234567) begin errors++; $display("FAIL full_w0 got %h want 01234567", cap[0]); end
      checks++; if (cap[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL full_w1 got %h want deadbeef", cap[1]); end
      checks++; if (cap[2] !== 32'h000000A5) begin errors++; $display("FAIL full_w2_pad got %h want 000000a5", cap[2]); end
      checks++; if (dut_clk_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL full_end got clk_en=%b err=%b want 1,0", dut_clk_en, err); end
      checks++; if (viol != 0) begin errors++; $display("FAIL full_viol got %0d want 0", viol); end
      $display("test_full_dump se=%0d words=%0d", se_cnt, word_cnt);
   endtask

   task automatic test_ack_timeout;
      int req_cyc = 0;
      bit to = 1;
      prep(CHAIN0);
      ack_en = 0;
      pulse_start;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (buf_val_op) req_cyc++;
         if (!busy) begin to = 0; break; end
      end
      checks++; if (to) begin errors++; $display("FAIL ackto_bound got busy want idle"); end
      checks++; if (req_cyc != TIMEOUT + 1) begin errors++; $display("FAIL ackto_req_cycles got %0d want %0d", req_cyc, TIMEOUT + 1); end
      checks++; if (err !== 1'b1 || dut_clk_en !== 1'b1) begin errors++; $display("FAIL ackto_err got err=%b clk_en=%b want 1,1", err, dut_clk_en); end
      checks++; if (se_cnt != 0 || word_cnt !== 7'd0) begin errors++; $display("FAIL ackto_no_shift got se=%0d wc=%0d want 0,0", se_cnt, word_cnt); end
      repeat (3) @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ackto_sticky got %b want 1", err); end
      ack_en = 1;
      $display("test_ack_timeout req_cycles=%0d", req_cyc);
   endtask

   task automatic test_mid_reset;
      bit to = 1;
      prep(CHAIN0);
      pulse_start;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (word_cnt == 7'd1 && se_cnt >= 40) begin to = 0; break; end
      end
      checks++; if (to || scan_en !== 1'b1) begin errors++; $display("FAIL mreset_reach got to=%0b se=%b want 0,1", to, scan_en); end
      @(posedge clk); #1 reset = 1; start = 1;
      @(posedge clk); #1 reset = 0; start = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dut_clk_en !== 1'b1 ||
                    scan_en !== 1'b0 || buf_val_op !== 1'b0 || word_cnt !== 7'd0)
         begin errors++; $display("FAIL mreset_outs got busy=%b done=%b err=%b clk_en=%b se=%b val=%b wc=%0d want 0,0,0,1,0,0,0",
                                  busy, done, err, dut_clk_en, scan_en, buf_val_op, word_cnt); end
      prep(CHAIN0);
      pulse_start;
      wait_idle(to);
      checks++; if (to || se_cnt != 72 || word_cnt !== 7'd3) begin errors++; $display("FAIL mreset_rerun got to=%0b se=%0d wc=%0d want 0,72,3", to, se_cnt, word_cnt); end
      checks++; if (cap[0] !== 32'h01234567 || cap[1] !== 32'hDEADBEEF || cap[2] !== 32'h000000A5)
         begin errors++; $display("FAIL mreset_words got %h %h %h want 01234567 deadbeef 000000a5", cap[0], cap[1], cap[2]); end
      $display("test_mid_reset se=%0d words=%0d", se_cnt, word_cnt);
   endtask

   task automatic test_ignore_busy;
      bit to = 1;
      prep(CHAIN1);
      pulse_start;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (se_cnt >= 10) begin to = 0; break; end
      end
      @(posedge clk); #1 start = 1;
      @(negedge clk); inject = 1;
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || scan_en !== 1'b1 || word_cnt !== 7'd0)
         begin errors++; $display("FAIL ign_mid got busy=%b se=%b wc=%0d want 1,1,0", busy, scan_en, word_cnt); end
      @(negedge clk);
      checks++; if (word_cnt !== 7'd0) begin errors++; $display("FAIL ign_wc got %0d want 0", word_cnt); end
      wait_idle(to);
      checks++; if (to || se_cnt != 72 || done_cnt != 1 || word_cnt !== 7'd3)
         begin errors++; $display("FAIL ign_end got to=%0b se=%0d done=%0d wc=%0d want 0,72,1,3", to, se_cnt, done_cnt, word_cnt); end
      checks++; if (cap[0] !== 32'h89ABCDEF || cap[1] !== 32'hCAFEF00D || cap[2] !== 32'h0000003C)
         begin errors++; $display("FAIL ign_words got %h %h %h want 89abcdef cafef00d 0000003c", cap[0], cap[1], cap[2]); end
      $display("test_ignore_busy se=%0d words=%0d", se_cnt, word_cnt);
   endtask

   task automatic test_commit_timeout;
      bit to;
      prep(CHAIN0);
      commit_en = 0;
      pulse_start;
      wait_idle(to);
      checks++; if (to || err !== 1'b1 || dut_clk_en !== 1'b1)
         begin errors++; $display("FAIL cto_err got to=%0b err=%b clk_en=%b want 0,1,1", to, err, dut_clk_en); end
      checks++; if (word_cnt !== 7'd0 || se_cnt != 32 || done_cnt != 0)
         begin errors++; $display("FAIL cto_counts got wc=%0d se=%0d done=%0d want 0,32,0", word_cnt, se_cnt, done_cnt); end
      commit_en = 1;
      prep(CHAIN1);
      pulse_start;
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL cto_clear got %b want 0", err); end
      wait_idle(to);
      checks++; if (to || se_cnt != 72 || word_cnt !== 7'd3 || err !== 1'b0)
         begin errors++; $display("FAIL cto_rerun got to=%0b se=%0d wc=%0d err=%b want 0,72,3,0", to, se_cnt, word_cnt, err); end
      checks++; if (cap[2] !== 32'h0000003C) begin errors++; $display("FAIL cto_w2 got %h want 0000003c", cap[2]); end
      $display("test_commit_timeout se=%0d words=%0d", se_cnt, word_cnt);
   endtask

   initial begin
      test_reset;
      test_full_dump;
      test_ack_timeout;
      test_mid_reset;
      test_ignore_busy;
      test_commit_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
